// File: rtl/data_memory_access_unit_if.sv
// Request/response bundle between the MEM stage (master) and the data memory
// responder (slave).
interface data_memory_access_unit_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Mem_Size;
  logic        Mem_Unsigned;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic [31:0] Read_Data;
  logic        Mem_Busy;
  logic        Mem_Done;
  logic        Mem_Error;

  modport master (
    output MemRead, MemWrite, Mem_Size, Mem_Unsigned, Address, Write_Data,
    input  Read_Data, Mem_Busy, Mem_Done, Mem_Error
  );

  modport slave (
    input  MemRead, MemWrite, Mem_Size, Mem_Unsigned, Address, Write_Data,
    output Read_Data, Mem_Busy, Mem_Done, Mem_Error
  );
endinterface

// File: rtl/data_memory_access_unit.sv
// Fixed-latency data memory responder: alignment check, lane-masked stores and
// sign/zero-extended loads on an internal word-addressed array.
module data_memory_access_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  data_memory_access_unit_if.slave    bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [AW-1:0]   idx_r;
  logic [1:0]      off_r;
  logic [1:0]      size_r;
  logic            uns_r;
  logic            is_write_r;
  logic [31:0]     wdata_r;
  logic [31:0]     read_data_r;
  logic            busy_r, done_r, error_r;

  logic            req_s, bad_s, size_bad_s;
  logic            accept_s, reject_s, access_s;
  logic [3:0]      be_s;
  logic [31:0]     wlane_s;
  logic            unused_addr_s;

  logic [31:0]     mem_r [DEPTH_WORDS];

  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{~uns & b[7]}}, b};
      2'b01:   res = {{16{~uns & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign req_s         = bus.MemRead | bus.MemWrite;
  assign unused_addr_s = ^bus.Address[31:AW+2];

  // Request legality: direction conflict, illegal size, or misalignment.
  always_comb begin
    size_bad_s = 1'b1;
    case (bus.Mem_Size)
      2'b00:   size_bad_s = 1'b0;
      2'b01:   size_bad_s = bus.Address[0];
      2'b10:   size_bad_s = (bus.Address[1:0] != 2'b00);
      default: size_bad_s = 1'b1;
    endcase
    bad_s = (bus.MemRead & bus.MemWrite) | size_bad_s;
  end

  // Next-state and latency counter.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    reject_s = 1'b0;
    access_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && bad_s) begin
          reject_s = 1'b1;
        end else if (req_s) begin
          accept_s = 1'b1;
          cnt_s    = CNT_LOAD;
          state_s  = WAIT;
        end else begin
          state_s  = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r != '0) begin
          cnt_s    = cnt_r - CW'(1);
        end else begin
          access_s = 1'b1;
          state_s  = DONE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Store lane enables and replicated store data from the latched request.
  always_comb begin
    be_s    = 4'b0000;
    wlane_s = wdata_r;
    case (size_r)
      2'b00: begin
        be_s    = 4'b0001 << off_r;
        wlane_s = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        be_s    = off_r[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata_r[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wlane_s = wdata_r;
      end
    endcase
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      off_r       <= 2'b00;
      size_r      <= 2'b00;
      uns_r       <= 1'b0;
      is_write_r  <= 1'b0;
      wdata_r     <= 32'h0000_0000;
      read_data_r <= 32'h0000_0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        idx_r      <= bus.Address[AW+1:2];
        off_r      <= bus.Address[1:0];
        size_r     <= bus.Mem_Size;
        uns_r      <= bus.Mem_Unsigned;
        is_write_r <= bus.MemWrite;
        wdata_r    <= bus.Write_Data;
      end
      if (access_s && !is_write_r) begin
        read_data_r <= load_extend(mem_r[idx_r], size_r, off_r, uns_r);
      end
      busy_r  <= (state_s == WAIT);
      done_r  <= (state_s == DONE);
      error_r <= reject_s;
    end
  end

  // Data array: lane-masked commit at the completion edge only; never reset.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < 4; k++) begin
      if (access_s && is_write_r && be_s[k]) begin
        mem_r[idx_r][8*k +: 8] <= wlane_s[8*k +: 8];
      end
    end
  end

  assign bus.Read_Data = read_data_r;
  assign bus.Mem_Busy  = busy_r;
  assign bus.Mem_Done  = done_r;
  assign bus.Mem_Error = error_r;

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Scoreboard bench for data_memory_access_unit: expected load results are
// queued when a request is driven and popped when Mem_Done is seen.
module tb_data_memory_access_unit;

  localparam int LAT = 2;

  logic Clk;
  logic Reset;
  data_memory_access_unit_if bus_if ();

  data_memory_access_unit #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0000_0000;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    bus_if.MemRead      = rd;
    bus_if.MemWrite     = wr;
    bus_if.Mem_Size     = size;
    bus_if.Mem_Unsigned = uns;
    bus_if.Address      = addr;
    bus_if.Write_Data   = wdata;
  endtask

  task automatic idle_req();
    drive_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // Follows an accepted request from its sampling edge to Mem_Done.
  task automatic complete(input string tag, input bit is_read, input bit drop);
    int k = 0;
    int busy_n = 0;
    bit seen = 1'b0;
    logic [31:0] exp;
    while (!seen && k <= LAT + 3) begin
      @(posedge Clk); #1;
      if (bus_if.Mem_Busy) busy_n++;
      if (bus_if.Mem_Done) seen = 1'b1;
      else k++;
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_done_edge"}, k, LAT);
    check_val({tag, "_busy_cycles"}, busy_n, LAT);
    if (seen && is_read) begin
      if (exp_q.size() == 0) begin
        check_val({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check_val({tag, "_rdata"}, bus_if.Read_Data, exp);
        last_rd = exp;
      end
    end
    if (drop) idle_req();
  endtask

  task automatic access(input string tag, input logic rd, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
    drive_req(rd, ~rd, size, uns, addr, wdata);
    if (rd) exp_q.push_back(exp);
    complete(tag, rd, 1'b1);
    @(posedge Clk); #1;
    check_val({tag, "_idle_flags"}, {29'd0, bus_if.Mem_Busy, bus_if.Mem_Done, bus_if.Mem_Error}, 32'd0);
  endtask

  task automatic reject(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr);
    drive_req(rd, wr, size, 1'b0, addr, 32'hA5A5_A5A5);
    @(posedge Clk); #1;
    check_val({tag, "_err_flags"}, {29'd0, bus_if.Mem_Busy, bus_if.Mem_Done, bus_if.Mem_Error}, 32'd1);
    check_val({tag, "_rdata_kept"}, bus_if.Read_Data, last_rd);
    idle_req();
    @(posedge Clk); #1;
    check_val({tag, "_err_pulse_end"}, {29'd0, bus_if.Mem_Busy, bus_if.Mem_Done, bus_if.Mem_Error}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    idle_req();
    #1;
    check_val("reset_rdata", bus_if.Read_Data, 32'h0);
    check_val("reset_flags", {29'd0, bus_if.Mem_Busy, bus_if.Mem_Done, bus_if.Mem_Error}, 32'd0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check_val("idle_flags", {29'd0, bus_if.Mem_Busy, bus_if.Mem_Done, bus_if.Mem_Error}, 32'd0);
      check_val("idle_rdata", bus_if.Read_Data, 32'h0);
    end

    access("sw_10",   1'b0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0);
    access("lw_10",   1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    access("lb_13",   1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE);
    access("lbu_13",  1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_00DE);
    access("lh_12",   1'b1, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_DEAD);
    access("lhu_10",  1'b1, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_BEEF);
    access("lb_10",   1'b1, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFEF);

    access("sb_11",   1'b0, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF55, 32'h0);
    access("lw_sb",   1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_55EF);
    access("sh_12",   1'b0, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, 32'h0);
    access("lw_sh",   1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_55EF);
    access("lw_alias",1'b1, 2'b10, 1'b1, 32'h410, 32'h0, 32'h1234_55EF);

    reject("rej_lw_12",   1'b1, 1'b0, 2'b10, 32'h12);
    reject("rej_sh_11",   1'b0, 1'b1, 2'b01, 32'h11);
    reject("rej_size11",  1'b1, 1'b0, 2'b11, 32'h10);
    reject("rej_rd_wr",   1'b1, 1'b1, 2'b10, 32'h10);
    access("lw_after_rej", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_55EF);

    // Request held through DONE is taken again as a fresh access.
    drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    exp_q.push_back(32'h1234_55EF);
    complete("hold_a", 1'b1, 1'b0);
    @(posedge Clk); #1;
    check_val("hold_gap_flags", {29'd0, bus_if.Mem_Busy, bus_if.Mem_Done, bus_if.Mem_Error}, 32'd0);
    exp_q.push_back(32'h1234_55EF);
    complete("hold_b", 1'b1, 1'b1);
    @(posedge Clk); #1;

    access("sw_20_zero", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0);
    drive_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678);
    @(posedge Clk); #1;
    check_val("rst_wr_busy", 32'(bus_if.Mem_Busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check_val("rst_async_rdata", bus_if.Read_Data, 32'h0);
    check_val("rst_async_flags", {29'd0, bus_if.Mem_Busy, bus_if.Mem_Done, bus_if.Mem_Error}, 32'd0);
    last_rd = 32'h0;
    idle_req();
    @(posedge Clk);
    #2 Reset = 1'b0;
    @(posedge Clk); #1;
    check_val("rst_release_flags", {29'd0, bus_if.Mem_Busy, bus_if.Mem_Done, bus_if.Mem_Error}, 32'd0);
    access("sw_40",  1'b0, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0);
    access("lw_40",  1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D);
    access("lw_20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0000_0000);

    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
